// File: rtl/drum_operand_stage.sv
// Two-stage DRUM operand truncation pipeline: S1 registers the raw operands, S2 registers
// the 8-bit truncated operands, one-hot shift codes and zero flag, with valid/ready flow control.
module drum_operand_stage #(
   parameter bit ROUND_LSB = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_ta,
   output logic [7:0]  out_tb,
   output logic [7:0]  out_sha_oh,
   output logic [7:0]  out_shb_oh,
   output logic        out_zero
);

   typedef struct packed {
      logic [7:0] t;
      logic [7:0] sh_oh;
   } trunc_t;

   // Leading-one detect over bits 15..8; the ascending loop lets the highest set bit win.
   function automatic trunc_t truncate(input logic [15:0] x);
      trunc_t r;
      r.t     = x[7:0];
      r.sh_oh = '0;
      for (int p = 8; p < 16; p++) begin
         if (x[p]) begin
            r.t          = x[p -: 8];
            r.sh_oh      = '0;
            r.sh_oh[p-8] = 1'b1;
         end
      end
      if (ROUND_LSB && (x[15:8] != 8'h00)) r.t[0] = 1'b1;
      return r;
   endfunction

   logic        s1_valid;
   logic [15:0] s1_a;
   logic [15:0] s1_b;
   logic        s2_valid;
   logic        s2_load;
   trunc_t      ra;
   trunc_t      rb;

   // S2 takes a new pair whenever it is empty or its current pair leaves this cycle.
   assign s2_load   = !s2_valid || out_ready;
   assign in_ready  = rst_n && (!s1_valid || s2_load);
   assign out_valid = s2_valid;

   // NOTE: always_comb gives every output a default before any conditional logic so no latch can form.
   always_comb begin
      ra = '0;
      rb = '0;
      ra = truncate(s1_a);
      rb = truncate(s1_b);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a <= in_a;
            s1_b <= in_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         out_ta     <= '0;
         out_tb     <= '0;
         out_sha_oh <= '0;
         out_shb_oh <= '0;
         out_zero   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_ta     <= ra.t;
            out_tb     <= rb.t;
            out_sha_oh <= ra.sh_oh;
            out_shb_oh <= rb.sh_oh;
            out_zero   <= (s1_a == 16'h0000) || (s1_b == 16'h0000);
         end
      end
   end

endmodule

// File: tb/tb_drum_operand_stage.sv
// Directed bench for drum_operand_stage: ROUND_LSB=1 and ROUND_LSB=0 instances share stimulus,
// expected values are hand-computed constants.
module tb_drum_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;

   logic        in_ready,  out_valid,  out_zero;
   logic [7:0]  out_ta,    out_tb,     out_sha_oh,  out_shb_oh;
   logic        z_in_ready, z_out_valid, z_out_zero;
   logic [7:0]  z_out_ta,  z_out_tb,   z_out_sha_oh, z_out_shb_oh;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   drum_operand_stage #(.ROUND_LSB(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_ta(out_ta), .out_tb(out_tb), .out_sha_oh(out_sha_oh), .out_shb_oh(out_shb_oh),
      .out_zero(out_zero)
   );

   drum_operand_stage #(.ROUND_LSB(1'b0)) u_dut_trunc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(z_out_valid), .out_ready(out_ready),
      .out_ta(z_out_ta), .out_tb(z_out_tb), .out_sha_oh(z_out_sha_oh), .out_shb_oh(z_out_shb_oh),
      .out_zero(z_out_zero)
   );

   // Expected {valid, ta, tb, sha, shb, zero}
   localparam logic [33:0] E_IDLE = 34'h0;
   localparam logic [33:0] E_P1   = {1'b1, 8'hA5, 8'h03, 8'h00, 8'h00, 1'b0};
   localparam logic [33:0] E_P2   = {1'b1, 8'hFF, 8'h81, 8'h80, 8'h01, 1'b0};
   localparam logic [33:0] E_P3   = {1'b1, 8'h91, 8'h01, 8'h10, 8'h00, 1'b0};
   localparam logic [33:0] E_P4   = {1'b1, 8'h00, 8'hFF, 8'h00, 8'h40, 1'b1};
   localparam logic [33:0] Z_P2   = {1'b1, 8'hFF, 8'h80, 8'h80, 8'h01, 1'b0};
   localparam logic [33:0] Z_P3   = {1'b1, 8'h90, 8'h01, 8'h10, 8'h00, 1'b0};

   function automatic logic [33:0] obs();
      return {out_valid, out_ta, out_tb, out_sha_oh, out_shb_oh, out_zero};
   endfunction

   function automatic logic [33:0] obs_z();
      return {z_out_valid, z_out_ta, z_out_tb, z_out_sha_oh, z_out_shb_oh, z_out_zero};
   endfunction

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
      in_valid = v;
      in_a     = a;
      in_b     = b;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 16'h0, 16'h0);

      // Reset state
      step();
      step();
      check("reset_outputs", 64'(obs()), 64'(E_IDLE));
      check("reset_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Single zero-shift pair, two-edge latency
      drive(1'b1, 16'h00A5, 16'h0003);
      step();
      drive(1'b0, 16'h0, 16'h0);
      check("p1_not_yet", 64'(out_valid), 64'd0);
      step();
      check("p1_out", 64'(obs()), 64'(E_P1));
      check("p1_out_trunc", 64'(obs_z()), 64'(E_P1));
      step();
      check("p1_drained", 64'(out_valid), 64'd0);

      // Back-to-back stream: max/min shift, LSB forcing, zero operand
      drive(1'b1, 16'hFFFF, 16'h0100);
      step();
      drive(1'b1, 16'h1200, 16'h0001);
      step();
      check("p2_out", 64'(obs()), 64'(E_P2));
      check("p2_out_trunc", 64'(obs_z()), 64'(Z_P2));
      drive(1'b1, 16'h0000, 16'h7FFF);
      step();
      check("p3_out", 64'(obs()), 64'(E_P3));
      check("p3_out_trunc", 64'(obs_z()), 64'(Z_P3));
      drive(1'b0, 16'h0, 16'h0);
      step();
      check("p4_out", 64'(obs()), 64'(E_P4));
      check("p4_out_trunc", 64'(obs_z()), 64'(E_P4));
      step();
      check("stream_drained", 64'(out_valid), 64'd0);

      // Backpressure: two pairs fill the pipe, then hold six cycles
      out_ready = 1'b0;
      drive(1'b1, 16'h00A5, 16'h0003);
      step();
      check("bp_ready_after_1", 64'(in_ready), 64'd1);
      drive(1'b1, 16'hFFFF, 16'h0100);
      step();
      check("bp_ready_after_2", 64'(in_ready), 64'd0);
      check("bp_head", 64'(obs()), 64'(E_P1));
      drive(1'b1, 16'h1200, 16'h0001);
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("bp_hold_out_%0d", i), 64'(obs()), 64'(E_P1));
         check($sformatf("bp_hold_rdy_%0d", i), 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      check("bp_out2", 64'(obs()), 64'(E_P2));
      drive(1'b1, 16'h0000, 16'h7FFF);
      step();
      check("bp_out3", 64'(obs()), 64'(E_P3));
      drive(1'b0, 16'h0, 16'h0);
      step();
      check("bp_out4", 64'(obs()), 64'(E_P4));
      step();
      check("bp_drained", 64'(out_valid), 64'd0);

      // Reset with both stages full
      out_ready = 1'b0;
      drive(1'b1, 16'hFFFF, 16'h0100);
      step();
      drive(1'b1, 16'h1200, 16'h0001);
      step();
      check("rst_pre_full", 64'(obs()), 64'(E_P2));
      drive(1'b0, 16'h0, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_out", 64'(obs()), 64'(E_IDLE));
      check("rst_async_ready", 64'(in_ready), 64'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 16'h0000, 16'h7FFF);
      step();
      drive(1'b0, 16'h0, 16'h0);
      check("rst_no_stale", 64'(out_valid), 64'd0);
      step();
      check("rst_new_pair", 64'(obs()), 64'(E_P4));
      step();
      check("rst_drained", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
